// File: rtl/tetromino_bag_gen.sv
// -----------------------------------------------------------------------------
// tetromino_bag_gen
//
// Piece source for the game core. A 16-bit Galois LFSR drives a 7-bag
// randomiser. The generated pieces go into a small registered queue. The head
// entry is handed to the shape-lookup stage over a valid/ready handshake. The
// remaining entries feed the "next pieces" preview display.
//
// Optional feature macro: SEVEN_BAG_EN
//   defined   : 7-bag selection. Every aligned group of 7 pieces after a
//               restart is a permutation of I,J,L,O,S,T,Z.
//   undefined : no bag mask. Each piece is an independent uniform draw,
//               computed as (lfsr[7:0]*7)>>8.
//
// Parameters
//   QUEUE_DEPTH   total queue entries (head + QUEUE_DEPTH-1 previews), 2..8
//   SEED_DEFAULT  LFSR value at reset and replacement for a zero seed
//
// Ports
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   seed_load      1-cycle pulse: load seed, flush queue, restart bag
//   seed[15:0]     new LFSR value, sampled while seed_load=1
//   piece_ready    consumer accepts the head piece this cycle
//   piece_valid    head entry is valid
//   piece          head piece (.data: I=0 J=1 L=2 O=3 S=4 T=5 Z=6, 7=none)
//   preview        entries 1..QUEUE_DEPTH-1 (index 0 = piece after the head)
//   preview_valid  per-slot valid bits for preview
// -----------------------------------------------------------------------------

package tetromino_pkg;
   typedef struct packed {
      logic [2:0] data;
   } tetromino_idx_t;

   localparam logic [2:0] NO_PIECE = 3'd7;
endpackage

module tetromino_bag_gen
   import tetromino_pkg::*;
#(
   parameter int          QUEUE_DEPTH  = 4,
   parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                seed_load,
   input  logic [15:0]                         seed,
   input  logic                                piece_ready,
   output logic                                piece_valid,
   output tetromino_idx_t                      piece,
   output tetromino_idx_t [QUEUE_DEPTH-2:0]    preview,
   output logic [QUEUE_DEPTH-2:0]              preview_valid
);

   localparam int          CW        = $clog2(QUEUE_DEPTH + 1);
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [15:0]            lfsr_q, lfsr_d;
   logic [CW-1:0]          count_q, count_d;
   logic [QUEUE_DEPTH-1:0] valid_q, valid_d;
   logic [2:0]             data_q [QUEUE_DEPTH];
   logic [2:0]             data_d [QUEUE_DEPTH];

   // ---------------------------------------------------------------------
   // Handshake and push decision
   // ---------------------------------------------------------------------
   logic          pop;
   logic          push;
   logic [CW-1:0] tail;
   logic [2:0]    chosen;

   assign pop  = valid_q[0] & piece_ready;
   // A full queue can still accept a new piece when the head leaves in the
   // same cycle, so the pipeline sustains one piece per clock.
   assign push = (count_q < CW'(QUEUE_DEPTH)) | pop;
   // When popping, every entry slides down one place, so the tail slot
   // also moves down by one.
   assign tail = pop ? (count_q - CW'(1)) : count_q;

   // ---------------------------------------------------------------------
   // Piece selection
   // ---------------------------------------------------------------------
`ifdef SEVEN_BAG_EN
   logic [6:0]  mask_q, mask_d;
   logic [2:0]  cnt;
   logic [10:0] prod;
   logic [2:0]  k;
   logic [2:0]  rank;
   logic        found;
   logic [6:0]  mask_cleared;

   // The scaled product maps lfsr[7:0] onto 0..cnt-1 without a divider.
   always_comb begin
      cnt = 3'd0;
      for (int b = 0; b < 7; b++) begin
         cnt = cnt + {2'b00, mask_q[b]};
      end
      prod = {3'b000, lfsr_q[7:0]} * {8'h00, cnt};
      k    = 3'(prod >> 8);
   end

   // Walk the mask from bit 0 upward and pick the k-th remaining piece.
   always_comb begin
      chosen = 3'd0;
      rank   = 3'd0;
      found  = 1'b0;
      for (int b = 0; b < 7; b++) begin
         if (mask_q[b]) begin
            if (!found && (rank == k)) begin
               chosen = 3'(b);
               found  = 1'b1;
            end
            rank = rank + 3'd1;
         end
      end
   end

   // Remove the chosen piece from the bag and start a new bag once it is empty.
   always_comb begin
      mask_cleared = mask_q & ~(7'b000_0001 << chosen);
      mask_d       = mask_q;
      if (seed_load) begin
         mask_d = 7'h7F;
      end else if (push) begin
         mask_d = (mask_cleared == 7'h00) ? 7'h7F : mask_cleared;
      end
   end
`else
   logic [10:0] prod;

   // Independent draw: (lfsr[7:0]*7)>>8 always lands in 0..6.
   always_comb begin
      prod   = {3'b000, lfsr_q[7:0]} * 11'd7;
      chosen = 3'(prod >> 8);
   end
`endif

   // ---------------------------------------------------------------------
   // LFSR and occupancy
   // ---------------------------------------------------------------------
   always_comb begin
      // Galois, right-shifting. The register free-runs every cycle, so the
      // sequence depends on when pieces are popped.
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
      if (seed_load) begin
         lfsr_d = (seed == 16'h0000) ? SEED_DEFAULT : seed;
      end
   end

   always_comb begin
      count_d = count_q;
      if (seed_load) begin
         count_d = '0;
      end else if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   // ---------------------------------------------------------------------
   // Queue storage: shift on pop, write at the tail on push.
   // Empty slots always carry NO_PIECE so the outputs need no extra masking.
   // ---------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         data_d[i]  = data_q[i];
         valid_d[i] = valid_q[i];
      end

      if (pop) begin
         for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
            data_d[i]  = data_q[i+1];
            valid_d[i] = valid_q[i+1];
         end
         data_d[QUEUE_DEPTH-1]  = NO_PIECE;
         valid_d[QUEUE_DEPTH-1] = 1'b0;
      end

      if (push) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (tail == CW'(i)) begin
               data_d[i]  = chosen;
               valid_d[i] = 1'b1;
            end
         end
      end

      // A reseed discards everything, including a handshake in this cycle.
      if (seed_load) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            data_d[i]  = NO_PIECE;
            valid_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_q  <= SEED_DEFAULT;
         count_q <= '0;
         valid_q <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            data_q[i] <= NO_PIECE;
         end
`ifdef SEVEN_BAG_EN
         mask_q  <= 7'h7F;
`endif
      end else begin
         lfsr_q  <= lfsr_d;
         count_q <= count_d;
         valid_q <= valid_d;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            data_q[i] <= data_d[i];
         end
`ifdef SEVEN_BAG_EN
         mask_q  <= mask_d;
`endif
      end
   end

   // ---------------------------------------------------------------------
   // Outputs come straight from the queue flops.
   // ---------------------------------------------------------------------
   assign piece_valid = valid_q[0];
   assign piece.data  = data_q[0];

   genvar gi;
   generate
      for (gi = 0; gi < QUEUE_DEPTH - 1; gi++) begin : g_preview
         assign preview[gi].data  = data_q[gi+1];
         assign preview_valid[gi] = valid_q[gi+1];
      end
   endgenerate

endmodule
